// File: rtl/fifo_flagged.sv
// Single-clock FIFO with fill level, programmable almost-full/almost-empty thresholds,
// synchronous flush, sticky overflow/underflow flags and an optional registered read port.
module fifo_flagged #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned WIDTHAD   = 4,
  parameter int unsigned AFULL_TH  = 2**WIDTHAD - 2,
  parameter int unsigned AEMPTY_TH = 2,
  parameter int unsigned Q_REG     = 0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [WIDTH-1:0]   D,
  input  logic               WR,
  input  logic               RD,
  input  logic               FLUSH,
  input  logic               CLR_ERR,
  output logic [WIDTH-1:0]   Q,
  output logic [WIDTHAD:0]   CNT,
  output logic               FULL,
  output logic               EMPTY,
  output logic               AFULL,
  output logic               AEMPTY,
  output logic               OVF,
  output logic               UDF
);

  localparam int unsigned NUMWORDS = 2**WIDTHAD;

  if (WIDTH < 1 || WIDTHAD < 1 || AFULL_TH < 1 || AFULL_TH > NUMWORDS ||
      AEMPTY_TH > NUMWORDS - 1 || Q_REG > 1) begin : g_param_check
    $error("fifo_flagged: illegal parameter value");
  end

  localparam logic [WIDTHAD:0] LvlFull   = (WIDTHAD+1)'(NUMWORDS);
  localparam logic [WIDTHAD:0] LvlAfull  = (WIDTHAD+1)'(AFULL_TH);
  localparam logic [WIDTHAD:0] LvlAempty = (WIDTHAD+1)'(AEMPTY_TH);

  logic [WIDTH-1:0]   mem [NUMWORDS];
  logic [WIDTHAD:0]   wcnt_q, rcnt_q, cnt;
  logic [WIDTHAD-1:0] rp;
  logic               ovf_q, udf_q;
  logic               full, empty, rd_ok, wr_ok, wr_drop, rd_udf;

  always_comb begin
    cnt     = wcnt_q - rcnt_q;
    full    = (cnt == LvlFull);
    empty   = (cnt == '0);
    rp      = rcnt_q[WIDTHAD-1:0];
    rd_ok   = RD & ~empty;
    // A read accepted in the same cycle frees a slot, so a write against full streams through.
    wr_ok   = WR & (~full | rd_ok);
    wr_drop = WR & full & ~RD & ~FLUSH;
    rd_udf  = RD & empty & ~FLUSH;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wcnt_q <= '0;
      rcnt_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (FLUSH) begin
        wcnt_q <= '0;
        rcnt_q <= '0;
      end else begin
        if (wr_ok) wcnt_q <= wcnt_q + 1'b1;
        if (rd_ok) rcnt_q <= rcnt_q + 1'b1;
      end
      // A new error wins over a simultaneous clear.
      ovf_q <= (ovf_q & ~CLR_ERR) | wr_drop;
      udf_q <= (udf_q & ~CLR_ERR) | rd_udf;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_ok && !FLUSH && !RST) begin
      mem[wcnt_q[WIDTHAD-1:0]] <= D;
    end
  end

  if (Q_REG == 1) begin : g_qreg
    logic [WIDTH-1:0] q_q;
    always_ff @(posedge CLK) begin
      if (RST) begin
        q_q <= '0;
      end else if (rd_ok && !FLUSH) begin
        q_q <= mem[rp];
      end
    end
    assign Q = q_q;
  end else begin : g_qcomb
    assign Q = mem[rp];
  end

  assign CNT    = cnt;
  assign FULL   = full;
  assign EMPTY  = empty;
  assign AFULL  = (cnt >= LvlAfull);
  assign AEMPTY = (cnt <= LvlAempty);
  assign OVF    = ovf_q;
  assign UDF    = udf_q;

endmodule

// File: tb/tb_fifo_flagged.sv
// Bench for fifo_flagged: fall-through and registered instances share stimulus and are
// checked every cycle against a queue-based model, plus directed literal expectations.
module tb_fifo_flagged;

  localparam int unsigned N = 16;

  logic        CLK = 1'b0;
  logic        RST, WR, RD, FLUSH, CLR_ERR;
  logic [31:0] D;

  logic [31:0] q0, q1;
  logic [4:0]  cnt0, cnt1;
  logic        full0, empty0, afull0, aempty0, ovf0, udf0;
  logic        full1, empty1, afull1, aempty1, ovf1, udf1;

  int nchecks = 0;
  int nerr    = 0;

  fifo_flagged #(.WIDTH(32), .WIDTHAD(4), .Q_REG(0)) u_dut0 (
    .CLK(CLK), .RST(RST), .D(D), .WR(WR), .RD(RD), .FLUSH(FLUSH), .CLR_ERR(CLR_ERR),
    .Q(q0), .CNT(cnt0), .FULL(full0), .EMPTY(empty0), .AFULL(afull0), .AEMPTY(aempty0),
    .OVF(ovf0), .UDF(udf0)
  );

  fifo_flagged #(.WIDTH(32), .WIDTHAD(4), .Q_REG(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .D(D), .WR(WR), .RD(RD), .FLUSH(FLUSH), .CLR_ERR(CLR_ERR),
    .Q(q1), .CNT(cnt1), .FULL(full1), .EMPTY(empty1), .AFULL(afull1), .AEMPTY(aempty1),
    .OVF(ovf1), .UDF(udf1)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, flags and registered Q as plain variables.
  logic [31:0] mq[$];
  bit          m_ovf, m_udf, m_valid;
  logic [31:0] m_q1;

  always @(posedge CLK) begin
    bit rd_ok, wr_ok;
    if (RST === 1'b1) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      m_q1    = '0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (CLR_ERR) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
      if (FLUSH) begin
        mq.delete();
      end else begin
        rd_ok = RD && (mq.size() > 0);
        wr_ok = WR && ((mq.size() < N) || rd_ok);
        if (WR && mq.size() == N && !RD) m_ovf = 1'b1;
        if (RD && mq.size() == 0) m_udf = 1'b1;
        if (rd_ok) m_q1 = mq.pop_front();
        if (wr_ok) mq.push_back(D);
      end
    end
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      chk("cnt0", 64'(cnt0), 64'(mq.size()));
      chk("cnt1", 64'(cnt1), 64'(mq.size()));
      chk("full0", 64'(full0), 64'(mq.size() == N));
      chk("full1", 64'(full1), 64'(mq.size() == N));
      chk("empty0", 64'(empty0), 64'(mq.size() == 0));
      chk("empty1", 64'(empty1), 64'(mq.size() == 0));
      chk("afull0", 64'(afull0), 64'(mq.size() >= 14));
      chk("afull1", 64'(afull1), 64'(mq.size() >= 14));
      chk("aempty0", 64'(aempty0), 64'(mq.size() <= 2));
      chk("aempty1", 64'(aempty1), 64'(mq.size() <= 2));
      chk("ovf0", 64'(ovf0), 64'(m_ovf));
      chk("ovf1", 64'(ovf1), 64'(m_ovf));
      chk("udf0", 64'(udf0), 64'(m_udf));
      chk("udf1", 64'(udf1), 64'(m_udf));
      chk("q1", 64'(q1), 64'(m_q1));
      if (mq.size() > 0) chk("q0", 64'(q0), 64'(mq[0]));
    end
  end

  task automatic cyc(input bit wr, input bit rd, input bit fl, input bit clr, input bit rst,
                     input logic [31:0] d);
    WR = wr; RD = rd; FLUSH = fl; CLR_ERR = clr; RST = rst; D = d;
    @(posedge CLK);
    #1;
    WR = 1'b0; RD = 1'b0; FLUSH = 1'b0; CLR_ERR = 1'b0; RST = 1'b0;
  endtask

  task automatic wr_word(input logic [31:0] d);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, d);
  endtask

  task automatic rd_word();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    RST = 1'b1; WR = 1'b0; RD = 1'b0; FLUSH = 1'b0; CLR_ERR = 1'b0; D = '0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("reset_cnt", 64'(cnt0), 64'd0);
    chk("reset_empty", 64'(empty0), 64'd1);
    chk("reset_q1", 64'(q1), 64'd0);

    // Fill with 1..16
    for (int i = 1; i <= 16; i++) begin
      wr_word(32'(i));
      chk("fill_cnt", 64'(cnt0), 64'(i));
      chk("fill_afull", 64'(afull0), 64'(i >= 14));
    end
    chk("fill_full", 64'(full0), 64'd1);

    // 17th write is dropped
    wr_word(32'h99);
    chk("ovf_set", 64'(ovf0), 64'd1);
    chk("ovf_cnt", 64'(cnt0), 64'd16);

    for (int i = 0; i < 16; i++) begin
      chk("drain_q0", 64'(q0), 64'(i + 1));
      rd_word();
      chk("drain_cnt", 64'(cnt0), 64'(15 - i));
    end
    chk("drain_empty", 64'(empty0), 64'd1);

    rd_word();
    chk("udf_set", 64'(udf0), 64'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("clr_ovf", 64'(ovf0), 64'd0);
    chk("clr_udf", 64'(udf0), 64'd0);

    // Full pass-through across the pointer wrap
    for (int i = 0; i < 16; i++) wr_word(32'h100 + 32'(i));
    for (int i = 0; i < 20; i++) begin
      chk("pass_q0", 64'(q0), (i < 16) ? 64'(32'h100 + 32'(i)) : 64'(32'h200 + 32'(i - 16)));
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h200 + 32'(i));
      chk("pass_cnt", 64'(cnt0), 64'd16);
    end
    chk("pass_ovf", 64'(ovf0), 64'd0);

    // Flush priority over WR/RD
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) wr_word(32'h300 + 32'(i));
    chk("pre_flush_cnt", 64'(cnt0), 64'd5);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD);
    chk("flush_cnt", 64'(cnt0), 64'd0);
    chk("flush_empty", 64'(empty0), 64'd1);
    chk("flush_ovf", 64'(ovf0), 64'd0);
    chk("flush_udf", 64'(udf0), 64'd0);
    wr_word(32'hA5);
    chk("flush_a5", 64'(q0), 64'hA5);

    // Registered read latency
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    wr_word(32'h11);
    wr_word(32'h22);
    rd_word();
    chk("qreg_first", 64'(q1), 64'h11);
    rd_word();
    chk("qreg_second", 64'(q1), 64'h22);
    idle();
    chk("qreg_hold", 64'(q1), 64'h22);

    // Reset mid-stream at CNT=9 with OVF set
    for (int i = 0; i < 17; i++) wr_word(32'h400 + 32'(i));
    for (int i = 0; i < 7; i++) rd_word();
    chk("pre_rst_cnt", 64'(cnt0), 64'd9);
    chk("pre_rst_ovf", 64'(ovf0), 64'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h77);
    chk("rst_cnt", 64'(cnt0), 64'd0);
    chk("rst_empty", 64'(empty0), 64'd1);
    chk("rst_aempty", 64'(aempty0), 64'd1);
    chk("rst_ovf", 64'(ovf0), 64'd0);
    idle();
    chk("rst_nostore", 64'(empty1), 64'd1);

    // Randomized traffic, write-heavy then read-heavy
    for (int i = 0; i < 3000; i++) begin
      int unsigned wp;
      wp = (i < 1500) ? 70 : 35;
      cyc($urandom_range(99) < wp, $urandom_range(99) < 50, $urandom_range(63) == 0,
          $urandom_range(31) == 0, $urandom_range(499) == 0, $urandom);
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
